// File: rtl/dff_pipe.sv
// Back-pressured register pipeline: WIDTH-bit payload through DEPTH valid-tagged stages,
// collapsing bubbles under stall, with synchronous flush of all held items.
module dff_pipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic [OCC_W-1:0] occ;

   // A stage can load when it is empty or everything downstream of it can move.
   always_comb begin : readyChain
      logic chain;
      chain = out_ready;
      rdy   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         chain  = ~valid_q[i] | chain;
         rdy[i] = chain;
      end
   end

   always_comb begin : nextState
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
      end

      if (rdy[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = in_data;
         end
      end

      for (int i = 1; i < DEPTH; i++) begin
         if (rdy[i]) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
               data_d[i] = data_q[i-1];
            end
         end
      end

      // Flush drops every item but leaves payload registers untouched.
      if (flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   always_comb begin : popCount
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ + OCC_W'(valid_q[i]);
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4) using an ordered
// scoreboard of accepted payloads and per-cycle expected handshake/occupancy values.
module tb_dff_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       inValid;
   logic       inReady;
   logic [7:0] inData;
   logic       outValid;
   logic       outReady;
   logic [7:0] outData;
   logic [2:0] occupancy;

   int         checks = 0;
   int         errors = 0;
   int         stepNo = 0;
   logic [7:0] sb [$];

   dff_pipe #(
      .WIDTH     (8),
      .DEPTH     (4),
      .RESET_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s step=%0d observed=%h expected=%h", tag, stepNo, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check the state left by the previous rising edge.
   task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic fl, input logic expRdy, input logic expOv,
                                input logic [2:0] expOcc);
      logic [7:0] expData;
      @(negedge clk);
      stepNo++;
      inValid  = iv;
      inData   = id;
      outReady = ordy;
      flush    = fl;
      #1;
      checkOutput("in_ready", {7'd0, inReady}, {7'd0, expRdy});
      checkOutput("out_valid", {7'd0, outValid}, {7'd0, expOv});
      checkOutput("occupancy", {5'd0, occupancy}, {5'd0, expOcc});
      if (expOv) begin
         checks++;
         assert (sb.size() != 0)
         else begin
            errors++;
            $error("[TB] FAIL sb_empty step=%0d observed=%0d expected=nonzero", stepNo, sb.size());
         end
         if (sb.size() != 0) begin
            if (ordy) begin
               expData = sb.pop_front();
               checkOutput("out_data", outData, expData);
            end else begin
               checkOutput("out_hold", outData, sb[0]);
            end
         end
      end
      if (fl) begin
         sb.delete();
      end else if (iv && expRdy) begin
         sb.push_back(id);
      end
   endtask

   initial begin
      reset    = 1'b0;
      flush    = 1'b0;
      inValid  = 1'b1;
      inData   = 8'hFF;
      outReady = 1'b0;

      repeat (2) begin
         @(negedge clk);
         #1;
         checkOutput("rst_out_valid", {7'd0, outValid}, 8'h00);
         checkOutput("rst_occupancy", {5'd0, occupancy}, 8'h00);
         checkOutput("rst_out_data", outData, 8'h00);
         checkOutput("rst_in_ready", {7'd0, inReady}, 8'h01);
      end
      @(negedge clk);
      inValid = 1'b0;
      reset   = 1'b1;

      // Back-to-back items with free-flowing output.
      applyStimulus(1, 8'h11, 1, 0, 1, 0, 3'd0);
      applyStimulus(1, 8'h22, 1, 0, 1, 0, 3'd1);
      applyStimulus(1, 8'h33, 1, 0, 1, 0, 3'd2);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd3);
      applyStimulus(0, 8'h00, 1, 0, 1, 1, 3'd3);
      applyStimulus(0, 8'h00, 1, 0, 1, 1, 3'd2);
      applyStimulus(0, 8'h00, 1, 0, 1, 1, 3'd1);

      // Stall fills the pipe, then release drains it without loss.
      applyStimulus(1, 8'hA0, 0, 0, 1, 0, 3'd0);
      applyStimulus(1, 8'hA1, 0, 0, 1, 0, 3'd1);
      applyStimulus(1, 8'hA2, 0, 0, 1, 0, 3'd2);
      applyStimulus(1, 8'hA3, 0, 0, 1, 0, 3'd3);
      applyStimulus(1, 8'hA4, 0, 0, 0, 1, 3'd4);
      applyStimulus(1, 8'hA4, 0, 0, 0, 1, 3'd4);
      applyStimulus(1, 8'hA4, 1, 0, 1, 1, 3'd4);
      applyStimulus(1, 8'hA5, 1, 0, 1, 1, 3'd4);

      // Full pipe streaming one item per cycle.
      applyStimulus(1, 8'hB0, 1, 0, 1, 1, 3'd4);
      applyStimulus(1, 8'hB1, 1, 0, 1, 1, 3'd4);
      applyStimulus(1, 8'hB2, 1, 0, 1, 1, 3'd4);
      applyStimulus(1, 8'hB3, 1, 0, 1, 1, 3'd4);
      applyStimulus(0, 8'h00, 1, 0, 1, 1, 3'd4);

      // Flush at occupancy 3 with a concurrent input that must vanish.
      applyStimulus(1, 8'h5A, 1, 1, 1, 1, 3'd3);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd0);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd0);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd0);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd0);

      // Refill under stall, then reset asynchronously between clock edges.
      applyStimulus(1, 8'h61, 0, 0, 1, 0, 3'd0);
      applyStimulus(1, 8'h62, 0, 0, 1, 0, 3'd1);
      applyStimulus(1, 8'h63, 0, 0, 1, 0, 3'd2);
      applyStimulus(1, 8'h64, 0, 0, 1, 0, 3'd3);
      applyStimulus(0, 8'h00, 0, 0, 0, 1, 3'd4);

      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async_out_valid", {7'd0, outValid}, 8'h00);
      checkOutput("async_occupancy", {5'd0, occupancy}, 8'h00);
      checkOutput("async_out_data", outData, 8'h00);
      checkOutput("async_in_ready", {7'd0, inReady}, 8'h01);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;

      // Fresh item after reset shows the full four-cycle latency.
      applyStimulus(1, 8'h77, 1, 0, 1, 0, 3'd0);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd1);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd1);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd1);
      applyStimulus(0, 8'h00, 1, 0, 1, 1, 3'd1);
      applyStimulus(0, 8'h00, 1, 0, 1, 0, 3'd0);

      checks++;
      assert (sb.size() == 0)
      else begin
         errors++;
         $error("[TB] FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
